// File: rtl/logic_pod_capture_pkg.sv
// logic_pod_capture_pkg: shared capture states, record layout and marker constants
package logic_pod_capture_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} la_cap_state_t;
    localparam logic [4:0] TRIG_POS_NONE = 5'h1F;
    localparam int LP_LANES = 8;
    localparam int LP_SPC = 20;
    localparam int LP_TS_WIDTH = 48;
    localparam int REC_W = LP_TS_WIDTH + 5 + LP_LANES * LP_SPC;
    typedef struct packed {
        logic [LP_TS_WIDTH-1:0]       ts;
        logic [4:0]                   trig_pos;
        logic [LP_LANES*LP_SPC-1:0]   samples;
    } la_cap_record_t;
endpackage

// File: rtl/logic_pod_capture_if.sv
// logic_pod_capture_if: valid/ready record stream from the capture stage to the memory arbiter
interface logic_pod_capture_if import logic_pod_capture_pkg::*; #(parameter int WIDTH = REC_W);
    logic             rec_valid;
    logic             rec_ready;
    logic [WIDTH-1:0] rec_data;
    modport master(output rec_valid, rec_data, input rec_ready);
    modport slave(input rec_valid, rec_data, output rec_ready);
endinterface

// File: rtl/logic_pod_record_fifo.sv
// logic_pod_record_fifo: first-word fall-through record FIFO with synchronous flush
module logic_pod_record_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic do_wr, do_rd;
    assign empty = wr_ptr_q == rd_ptr_q;
    assign full = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_rd = rd_en && !empty;
    // a full FIFO still accepts a write when the head leaves in the same cycle
    assign do_wr = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + (AW+1)'(do_wr);
            rd_ptr_q <= rd_ptr_q + (AW+1)'(do_rd);
        end
    always_ff @(posedge clk)
        if (do_wr && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
endmodule

// File: rtl/logic_pod_capture.sv
// logic_pod_capture: per-lane inversion, pattern trigger and change compression into a timestamped record FIFO
module logic_pod_capture import logic_pod_capture_pkg::*; #(
    parameter int               LANES = LP_LANES,
    parameter int               SPC = LP_SPC,
    parameter logic [LANES-1:0] LANE_INVERT = '0,
    parameter int               DEPTH = 16,
    parameter int               TS_WIDTH = LP_TS_WIDTH,
    parameter int               IDLE_MAX = 1023
) (
    input  logic                   clk_250mhz,
    input  logic                   rst_n,
    input  logic [LANES*SPC-1:0]   in_data,
    input  logic                   arm,
    input  logic [LANES-1:0]       trig_mask,
    input  logic [LANES-1:0]       trig_pattern,
    input  logic [15:0]            post_count,
    logic_pod_capture_if.master    rec,
    output logic [1:0]             state,
    output logic                   overflow,
    output logic [15:0]            drop_count
);
    localparam int IW = $clog2(IDLE_MAX + 1);
    localparam int RW = TS_WIDTH + 5 + LANES * SPC;
    logic [LANES*SPC-1:0] inv_mask, s1_q;
    logic [LANES-1:0] col [SPC];
    logic [LANES-1:0] last_q;
    la_cap_state_t state_q, state_d;
    logic [15:0] post_q, post_d, drop_q;
    logic [IW-1:0] idle_q, idle_d;
    logic [TS_WIDTH-1:0] ts_q;
    logic [RW-1:0] rec_q;
    logic [4:0] hit_pos, pos_d;
    logic hit, changed, wr_d, wr_q, overflow_q, full, empty, drop;
    for (genvar l = 0; l < LANES; l++) begin : g_inv
        assign inv_mask[l*SPC +: SPC] = {SPC{LANE_INVERT[l]}};
    end
    // regroup the lane-major S1 word into one LANES-wide column per sample slot
    always_comb begin
        for (int s = 0; s < SPC; s++)
            for (int l = 0; l < LANES; l++)
                col[s][l] = s1_q[l*SPC+s];
    end
    always_comb begin
        hit = 1'b0;
        hit_pos = TRIG_POS_NONE;
        changed = 1'b0;
        for (int s = SPC - 1; s >= 0; s--)
            if (((col[s] ^ trig_pattern) & trig_mask) == '0) begin
                hit = 1'b1;
                hit_pos = 5'(s);
            end
        for (int s = 0; s < SPC; s++)
            if (col[s] != last_q) changed = 1'b1;
    end
    always_comb begin
        state_d = state_q;
        post_d = post_q;
        idle_d = idle_q;
        wr_d = 1'b0;
        pos_d = TRIG_POS_NONE;
        if (arm) begin
            state_d = ARMED;
            idle_d = '0;
        end else if (state_q == ARMED && hit) begin
            wr_d = 1'b1;
            pos_d = hit_pos;
            idle_d = '0;
            post_d = post_count;
            state_d = post_count == 16'd0 ? DONE : CAPTURE;
        end else if (state_q == CAPTURE) begin
            wr_d = changed || idle_q == IW'(IDLE_MAX);
            idle_d = wr_d ? '0 : idle_q + 1'b1;
            post_d = wr_d ? post_q - 1'b1 : post_q;
            state_d = (wr_d && post_q == 16'd1) ? DONE : CAPTURE;
        end
    end
    // a record the FIFO cannot take is dropped but was already counted toward post_count
    assign drop = wr_q && full && !rec.rec_ready;
    always_ff @(posedge clk_250mhz or negedge rst_n)
        if (!rst_n) begin
            s1_q <= '0;
            last_q <= '0;
            state_q <= IDLE;
            post_q <= '0;
            idle_q <= '0;
            ts_q <= '0;
            wr_q <= 1'b0;
            rec_q <= '0;
            overflow_q <= 1'b0;
            drop_q <= '0;
        end else begin
            s1_q <= in_data ^ inv_mask;
            last_q <= col[SPC-1];
            state_q <= state_d;
            post_q <= post_d;
            idle_q <= idle_d;
            ts_q <= arm ? '0 : ts_q + 1'b1;
            wr_q <= wr_d;
            if (wr_d) rec_q <= {ts_q, pos_d, s1_q};
            overflow_q <= arm ? 1'b0 : (overflow_q | drop);
            drop_q <= arm ? '0 : drop_q + 16'(drop && drop_q != 16'hFFFF);
        end
    logic_pod_record_fifo #(.DEPTH(DEPTH), .WIDTH(RW)) u_fifo (
        .clk(clk_250mhz),
        .rst_n(rst_n),
        .flush(arm),
        .wr_en(wr_q),
        .wr_data(rec_q),
        .rd_en(rec.rec_ready),
        .rd_data(rec.rec_data),
        .full(full),
        .empty(empty)
    );
    assign rec.rec_valid = !empty;
    assign state = state_q;
    assign overflow = overflow_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_logic_pod_capture.sv
// tb_logic_pod_capture: directed checks of reset, trigger, keepalive, overflow, inversion and re-arm
module tb_logic_pod_capture;
    import logic_pod_capture_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic arm = 1'b0;
    logic [159:0] in_data = '0;
    logic [7:0] trig_mask = '0;
    logic [7:0] trig_pattern = '0;
    logic [15:0] post_count = '0;
    logic [1:0] state;
    logic overflow;
    logic [15:0] drop_count;
    la_cap_record_t rec;
    int checks = 0;
    int errors = 0;
    logic_pod_capture_if rif();
    logic_pod_capture #(
        .LANES(8), .SPC(20), .LANE_INVERT(8'h80), .DEPTH(16), .TS_WIDTH(48), .IDLE_MAX(15)
    ) dut (
        .clk_250mhz(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .arm(arm),
        .trig_mask(trig_mask),
        .trig_pattern(trig_pattern),
        .post_count(post_count),
        .rec(rif),
        .state(state),
        .overflow(overflow),
        .drop_count(drop_count)
    );
    always #2 clk = ~clk;
    assign rec = rif.rec_data;
    function automatic logic [159:0] blk(input logic [7:0] a, input logic [7:0] b, input int sc);
        logic [159:0] r;
        for (int l = 0; l < 8; l++)
            for (int s = 0; s < 20; s++)
                r[l*20+s] = (s < sc) ? a[l] : b[l];
        return r;
    endfunction
    function automatic logic [7:0] rawv(input int j);
        return (j % 2 == 1) ? 8'h81 : 8'h80;
    endfunction
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_rec(input string tag, input logic [47:0] ts, input logic [4:0] pos, input logic [159:0] smp);
        chk({tag, "_valid"}, 256'(rif.rec_valid), 256'(1));
        chk({tag, "_ts"}, 256'(rec.ts), 256'(ts));
        chk({tag, "_pos"}, 256'(rec.trig_pos), 256'(pos));
        chk({tag, "_smp"}, 256'(rec.samples), 256'(smp));
    endtask
    initial begin
        rif.rec_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) begin @(negedge clk); in_data = ~in_data; end
        chk("rst_state", 256'(state), 256'(0));
        chk("rst_valid", 256'(rif.rec_valid), 256'(0));
        chk("rst_ovf", 256'(overflow), 256'(0));
        chk("rst_drop", 256'(drop_count), 256'(0));
        rst_n = 1'b1;
        repeat (6) begin @(negedge clk); in_data = ~in_data; end
        chk("idle_state", 256'(state), 256'(0));
        chk("idle_valid", 256'(rif.rec_valid), 256'(0));
        chk("idle_data", 256'(rif.rec_data), 256'(0));
        // lane0 trigger at sample 7 of block 5, then constant input for keepalives
        rif.rec_ready = 1'b0;
        trig_mask = 8'h01; trig_pattern = 8'h01; post_count = 16'd3;
        @(negedge clk); arm = 1'b1; in_data = blk(8'h80, 8'h80, 0);
        @(negedge clk); arm = 1'b0;
        repeat (5) @(negedge clk);
        in_data = blk(8'h80, 8'h81, 7);
        @(negedge clk); in_data = blk(8'h81, 8'h81, 0);
        repeat (3) @(negedge clk);
        chk("trig_state", 256'(state), 256'(2));
        chk_rec("trig_rec", 48'd6, 5'd7, blk(8'h00, 8'h01, 7));
        repeat (55) @(negedge clk);
        chk("post_state", 256'(state), 256'(3));
        chk("post_ovf", 256'(overflow), 256'(0));
        rif.rec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_rec("keep", 48'(6 + 16 * i), i == 0 ? 5'd7 : TRIG_POS_NONE,
                    i == 0 ? blk(8'h00, 8'h01, 7) : blk(8'h01, 8'h01, 0));
            @(negedge clk);
        end
        chk("keep_empty", 256'(rif.rec_valid), 256'(0));
        // 20 changing blocks into a stalled FIFO
        rif.rec_ready = 1'b0;
        trig_mask = 8'h00; post_count = 16'd19;
        @(negedge clk); arm = 1'b1; in_data = blk(rawv(0), rawv(0), 0);
        for (int j = 1; j < 20; j++) begin
            @(negedge clk); arm = 1'b0; in_data = blk(rawv(j), rawv(j), 0);
        end
        repeat (7) @(negedge clk);
        chk("ovf_state", 256'(state), 256'(3));
        chk("ovf_flag", 256'(overflow), 256'(1));
        chk("ovf_drop", 256'(drop_count), 256'(4));
        for (int j = 0; j < 16; j++) begin
            logic [7:0] v;
            v = rawv(j) ^ 8'h80;
            rif.rec_ready = 1'b0;
            chk_rec("drain", 48'(j), j == 0 ? 5'd0 : TRIG_POS_NONE, blk(v, v, 0));
            @(negedge clk);
            chk_rec("stall", 48'(j), j == 0 ? 5'd0 : TRIG_POS_NONE, blk(v, v, 0));
            rif.rec_ready = 1'b1;
            @(negedge clk);
        end
        chk("drain_empty", 256'(rif.rec_valid), 256'(0));
        // inverted lane7 satisfies pattern bit7=0; re-arm while full
        rif.rec_ready = 1'b0;
        trig_mask = 8'h80; trig_pattern = 8'h00; post_count = 16'd1000;
        @(negedge clk); arm = 1'b1; in_data = blk(8'h80, 8'h80, 0);
        for (int j = 1; j < 25; j++) begin
            @(negedge clk); arm = 1'b0; in_data = blk(rawv(j), rawv(j), 0);
        end
        @(negedge clk);
        chk("inv_state", 256'(state), 256'(2));
        chk("inv_ovf", 256'(overflow), 256'(1));
        chk("inv_drop", 256'(drop_count), 256'(7));
        chk_rec("inv_rec", 48'd0, 5'd0, blk(8'h00, 8'h00, 0));
        arm = 1'b1; in_data = blk(8'h81, 8'h81, 0);
        @(negedge clk); arm = 1'b0;
        chk("rearm_valid", 256'(rif.rec_valid), 256'(0));
        chk("rearm_ovf", 256'(overflow), 256'(0));
        chk("rearm_drop", 256'(drop_count), 256'(0));
        chk("rearm_state", 256'(state), 256'(1));
        repeat (2) @(negedge clk);
        chk("rearm_cap", 256'(state), 256'(2));
        chk_rec("rearm_rec", 48'd0, 5'd0, blk(8'h01, 8'h01, 0));
        // asynchronous reset mid-capture
        #1 rst_n = 1'b0;
        #1;
        chk("arst_state", 256'(state), 256'(0));
        chk("arst_valid", 256'(rif.rec_valid), 256'(0));
        chk("arst_data", 256'(rif.rec_data), 256'(0));
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
